// File: rtl/breath_led.sv
// Breathing LED: a PWM whose duty ramps up over one slow period and down over the next.
// Three cascaded counters (base tick, PWM window, ramp step) plus a direction bit drive a registered compare.
module breath_led #(
    parameter logic [6:0] CNT_2US_MAX = 7'd100,
    parameter logic [9:0] CNT_2MS_MAX = 10'd1000,
    parameter logic [9:0] CNT_2S_MAX  = 10'd1000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic led
);

    logic [6:0] r_cnt_us;
    logic [9:0] r_cnt_ms;
    logic [9:0] r_cnt_s;
    logic       r_dir;
    logic       r_led;

    logic       w_tick_us;
    logic       w_tick_ms;
    logic       w_tick_s;
    logic       w_led_nxt;

    assign w_tick_us = (r_cnt_us == CNT_2US_MAX - 7'd1);
    assign w_tick_ms = w_tick_us && (r_cnt_ms == CNT_2MS_MAX - 10'd1);
    assign w_tick_s  = w_tick_ms && (r_cnt_s == CNT_2S_MAX - 10'd1);

    // Duty is cnt_s/CNT_2MS_MAX while brightening and its complement while dimming.
    assign w_led_nxt = r_dir ? (r_cnt_ms >= r_cnt_s) : (r_cnt_ms < r_cnt_s);

    // sys_rst_n is active-high despite its name.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            r_cnt_us <= 7'd0;
            r_cnt_ms <= 10'd0;
            r_cnt_s  <= 10'd0;
            r_dir    <= 1'b0;
            r_led    <= 1'b0;
        end else begin
            r_cnt_us <= w_tick_us ? 7'd0 : r_cnt_us + 7'd1;

            if (w_tick_ms)
                r_cnt_ms <= 10'd0;
            else if (w_tick_us)
                r_cnt_ms <= r_cnt_ms + 10'd1;

            if (w_tick_s)
                r_cnt_s <= 10'd0;
            else if (w_tick_ms)
                r_cnt_s <= r_cnt_s + 10'd1;

            if (w_tick_s)
                r_dir <= ~r_dir;

            r_led <= w_led_nxt;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_breath_led.sv
// Bench for breath_led: led is predicted from the number of clocks since the last reset
// using plain division/modulo arithmetic, plus literal checks of the breathing pattern.
module tb_breath_led;

    localparam int U = 2;
    localparam int M = 10;
    localparam int S = 10;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b1;
    logic led;

    int vectors = 0;
    int miscompares = 0;
    int k = 0;
    bit started = 0;
    logic exp_led = 1'b0;
    logic hist [0:799];
    logic hist2 [0:199];

    breath_led #(
        .CNT_2US_MAX(7'd2),
        .CNT_2MS_MAX(10'd10),
        .CNT_2S_MAX (10'd10)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .led      (led)
    );

    always #10 sys_clk = ~sys_clk;

    // led after the (n+1)-th clock out of reset, from the counter state after n clocks
    function automatic logic model_led(input int n);
        int ms, s, d;
        ms = (n / U) % M;
        s  = (n / (U * M)) % S;
        d  = (n / (U * M * S)) % 2;
        return d ? (ms >= s) : (ms < s);
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the model on the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge sys_clk);
        if (sys_rst_n) begin
            exp_led = 1'b0;
            k = 0;
            started = 1;
        end else if (started) begin
            exp_led = model_led(k);
            k++;
        end
        @(negedge sys_clk);
        if (started)
            check_bit("led_vs_model", led, exp_led);
    endtask

    initial begin
        int sum;
        int run;
        bit same;

        // model pinned against hand-computed figures
        sum = 0;
        for (int j = 0; j < 200; j++) sum += model_led(j);
        check_int("model_on_first_200", sum, 90);
        sum = 0;
        for (int j = 200; j < 400; j++) sum += model_led(j);
        check_int("model_on_next_200", sum, 110);

        // reset held for 10 clocks
        sys_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_bit("led_in_reset", led, 1'b0);
        end

        // release and record 800 clocks
        sys_rst_n = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            hist[i] = led;
        end

        sum = 0;
        for (int j = 0; j < 20; j++) sum += hist[j];
        check_int("first_window_on", sum, 0);

        sum = 0;
        for (int j = 60; j < 66; j++) sum += hist[j];
        check_int("win3_first6_on", sum, 6);
        sum = 0;
        for (int j = 66; j < 80; j++) sum += hist[j];
        check_int("win3_last14_on", sum, 0);

        sum = 0;
        for (int j = 0; j < 200; j++) sum += hist[j];
        check_int("on_first_200", sum, 90);
        sum = 0;
        for (int j = 200; j < 400; j++) sum += hist[j];
        check_int("on_next_200", sum, 110);
        sum = 0;
        for (int j = 200; j < 220; j++) sum += hist[j];
        check_int("first_dim_window_on", sum, 20);
        sum = 0;
        for (int j = 180; j < 200; j++) sum += hist[j];
        check_int("last_bright_window_on", sum, 18);

        same = 1;
        for (int j = 0; j < 400; j++) if (hist[j] !== hist[j + 400]) same = 0;
        check_bit("period_400_repeat", same, 1'b1);

        // advance to cnt_s=5, dir=1 (1100 clocks after release) then pulse reset
        for (int i = 0; i < 300; i++) tick();
        sys_rst_n = 1'b1;
        tick();
        check_bit("led_after_mid_reset", led, 1'b0);
        sys_rst_n = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            hist2[i] = led;
        end
        same = 1;
        for (int j = 0; j < 200; j++) if (hist2[j] !== hist[j]) same = 0;
        check_bit("restart_matches_first", same, 1'b1);

        // random reset pulses of 1..3 clocks at random points
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                run = $urandom_range(1, 3);
                sys_rst_n = 1'b1;
                for (int r = 0; r < run; r++) tick();
                sys_rst_n = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
